reg_wr_sched: RTL and testbench

- Write-port scheduler in front of the CPU register file.
- Arbitrates two write requesters onto the file's single write port: A (execute writeback) and B (memory load return).
- Expands the PCLINK pseudo register into two writes: LR first, then PC.
- Converts the 2-bit register mask code into the 32-bit byte-lane mask.
- Optionally enforces the privilege rule on STATUS writes.

---
 rtl/reg_wr_sched.sv | 145 ++++++++++++++
 tb/tb_reg_wr_sched.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wr_sched.sv
// Write-port scheduler for the register file: arbitrates A/B writers, splits PCLINK into LR then PC.
// Optional privilege check on STATUS writes when REG_WR_SCHED_PRIV_CHECK_EN is defined.
module reg_wr_sched #(
    parameter int          FAIR        = 1,
    parameter logic [31:0] LINK_OFFSET = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_sel,
    input  logic [31:0] a_data,
    input  logic [1:0]  a_mask,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [3:0]  b_sel,
    input  logic [31:0] b_data,
    input  logic [1:0]  b_mask,
    input  logic [31:0] pc_in,
    input  logic        mode,
    output logic        wr_en,
    output logic [3:0]  wr_sel,
    output logic [31:0] wr_data,
    output logic [31:0] wr_mask,
    output logic        busy,
    output logic        priv_fault
);
    localparam logic [3:0] SEL_STATUS = 4'hB;
    localparam logic [3:0] SEL_LR     = 4'hD;
    localparam logic [3:0] SEL_PCLINK = 4'hE;
    localparam logic [3:0] SEL_PC     = 4'hF;

    typedef enum logic {IDLE, LINK} state_e;

    typedef struct packed {
        logic [3:0]  sel;
        logic [31:0] data;
        logic [1:0]  mask;
    } req_t;

    function automatic logic [31:0] get_mask_32(input logic [1:0] code);
        case (code)
            2'd0:    return 32'h0000_00FF;
            2'd1:    return 32'h0000_FFFF;
            2'd2:    return 32'h00FF_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    state_e      state_q, state_d;
    logic        last_b_q;
    logic [31:0] pend_data_q;
    logic [1:0]  pend_mask_q;
    logic        grant_a, grant_b, accept, drop;
    req_t        req;
    logic        nxt_en, nxt_fault;
    logic [3:0]  nxt_sel;
    logic [31:0] nxt_data, nxt_mask;

    // last_b_q resets to B so A wins the first tie under round-robin.
    always_comb begin
        grant_a = a_valid && (!b_valid || (FAIR == 0) || last_b_q);
        grant_b = b_valid && !grant_a;
    end

    assign a_ready = !rst && (state_q == IDLE) && grant_a;
    assign b_ready = !rst && (state_q == IDLE) && grant_b;
    assign accept  = a_ready || b_ready;
    assign req     = grant_a ? '{sel: a_sel, data: a_data, mask: a_mask}
                             : '{sel: b_sel, data: b_data, mask: b_mask};

`ifdef REG_WR_SCHED_PRIV_CHECK_EN
    assign drop = (req.sel == SEL_STATUS) && mode;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign drop        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && req.sel == SEL_PCLINK) state_d = LINK;
            LINK:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered write port.
    always_comb begin
        nxt_en    = 1'b0;
        nxt_sel   = 4'd0;
        nxt_data  = 32'd0;
        nxt_mask  = 32'd0;
        nxt_fault = 1'b0;
        if (state_q == LINK) begin
            nxt_en   = 1'b1;
            nxt_sel  = SEL_PC;
            nxt_data = pend_data_q;
            nxt_mask = get_mask_32(pend_mask_q);
        end else if (accept) begin
            if (req.sel == SEL_PCLINK) begin
                nxt_en   = 1'b1;
                nxt_sel  = SEL_LR;
                nxt_data = pc_in + LINK_OFFSET;
                nxt_mask = 32'hFFFF_FFFF;
            end else if (drop) begin
                nxt_fault = 1'b1;
            end else begin
                nxt_en   = 1'b1;
                nxt_sel  = req.sel;
                nxt_data = req.data;
                nxt_mask = get_mask_32(req.mask);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            pend_data_q <= 32'd0;
            pend_mask_q <= 2'd0;
            wr_en       <= 1'b0;
            wr_sel      <= 4'd0;
            wr_data     <= 32'd0;
            wr_mask     <= 32'd0;
            busy        <= 1'b0;
            priv_fault  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_en      <= nxt_en;
            wr_sel     <= nxt_sel;
            wr_data    <= nxt_data;
            wr_mask    <= nxt_mask;
            busy       <= (state_d == LINK);
            priv_fault <= nxt_fault;
            if (accept) begin
                last_b_q    <= grant_b;
                pend_data_q <= req.data;
                pend_mask_q <= req.mask;
            end
        end
    end
endmodule

// File: tb/tb_reg_wr_sched.sv
// Bench for reg_wr_sched: two instances (round-robin/offset 1, fixed priority/offset -16),
// a cycle-level reference model compared every cycle, plus directed literal checks.
module tb_reg_wr_sched;
    localparam int N = 2;
    localparam logic [31:0] OFF0 = 32'd1;
    localparam logic [31:0] OFF1 = 32'hFFFF_FFF0;
`ifdef REG_WR_SCHED_PRIV_CHECK_EN
    localparam bit PRIV = 1'b1;
`else
    localparam bit PRIV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]       a_valid, a_ready, b_valid, b_ready, mode;
    logic [N-1:0][3:0]  a_sel, b_sel, wr_sel;
    logic [N-1:0][31:0] a_data, b_data, pc_in, wr_data, wr_mask;
    logic [N-1:0][1:0]  a_mask, b_mask;
    logic [N-1:0]       wr_en, busy, priv_fault;

    reg_wr_sched #(.FAIR(1), .LINK_OFFSET(OFF0)) u0 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid[0]), .a_ready(a_ready[0]), .a_sel(a_sel[0]), .a_data(a_data[0]), .a_mask(a_mask[0]),
        .b_valid(b_valid[0]), .b_ready(b_ready[0]), .b_sel(b_sel[0]), .b_data(b_data[0]), .b_mask(b_mask[0]),
        .pc_in(pc_in[0]), .mode(mode[0]), .wr_en(wr_en[0]), .wr_sel(wr_sel[0]), .wr_data(wr_data[0]),
        .wr_mask(wr_mask[0]), .busy(busy[0]), .priv_fault(priv_fault[0]));

    reg_wr_sched #(.FAIR(0), .LINK_OFFSET(OFF1)) u1 (
        .clk(clk), .rst(rst),
        .a_valid(a_valid[1]), .a_ready(a_ready[1]), .a_sel(a_sel[1]), .a_data(a_data[1]), .a_mask(a_mask[1]),
        .b_valid(b_valid[1]), .b_ready(b_ready[1]), .b_sel(b_sel[1]), .b_data(b_data[1]), .b_mask(b_mask[1]),
        .pc_in(pc_in[1]), .mode(mode[1]), .wr_en(wr_en[1]), .wr_sel(wr_sel[1]), .wr_data(wr_data[1]),
        .wr_mask(wr_mask[1]), .busy(busy[1]), .priv_fault(priv_fault[1]));

    int checks = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: the write each DUT must present in the current cycle.
    typedef struct {
        logic        en;
        logic [3:0]  sel;
        logic [31:0] data;
        logic [31:0] mask;
        logic        fault;
        logic        link;
    } exp_t;

    exp_t        cur[N];
    exp_t        pend[N];
    logic        last_b[N];
    logic        acc_a[N], acc_b[N];
    logic [31:0] mtab[4];

    function automatic exp_t no_wr();
        exp_t e;
        e = '{en: 1'b0, sel: 4'd0, data: 32'd0, mask: 32'd0, fault: 1'b0, link: 1'b0};
        return e;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            logic        ea, eb, fair;
            logic [3:0]  s;
            logic [31:0] d, off;
            logic [1:0]  m;
            exp_t        nxt;
            fair = (k == 0);
            off  = (k == 0) ? OFF0 : OFF1;
            ea = !rst && !cur[k].link && a_valid[k] && (!b_valid[k] || !fair || last_b[k]);
            eb = !rst && !cur[k].link && b_valid[k] && !ea;
            chk($sformatf("dut%0d a_ready", k), a_ready[k], ea);
            chk($sformatf("dut%0d b_ready", k), b_ready[k], eb);
            chk($sformatf("dut%0d wr_en", k), wr_en[k], cur[k].en);
            chk($sformatf("dut%0d busy", k), busy[k], cur[k].link);
            chk($sformatf("dut%0d priv_fault", k), priv_fault[k], cur[k].fault);
            if (cur[k].en) begin
                chk($sformatf("dut%0d wr_sel", k), wr_sel[k], cur[k].sel);
                chk($sformatf("dut%0d wr_data", k), wr_data[k], cur[k].data);
                chk($sformatf("dut%0d wr_mask", k), wr_mask[k], cur[k].mask);
            end
            acc_a[k] = ea;
            acc_b[k] = eb;
            nxt = no_wr();
            if (rst) begin
                last_b[k] = 1'b1;
            end else if (cur[k].link) begin
                nxt = pend[k];
            end else if (ea || eb) begin
                s = ea ? a_sel[k] : b_sel[k];
                d = ea ? a_data[k] : b_data[k];
                m = ea ? a_mask[k] : b_mask[k];
                last_b[k] = eb;
                if (s == 4'hE) begin
                    nxt = '{en: 1'b1, sel: 4'hD, data: pc_in[k] + off, mask: 32'hFFFF_FFFF,
                            fault: 1'b0, link: 1'b1};
                    pend[k] = '{en: 1'b1, sel: 4'hF, data: d, mask: mtab[m], fault: 1'b0, link: 1'b0};
                end else if (PRIV && s == 4'hB && mode[k]) begin
                    nxt.fault = 1'b1;
                end else begin
                    nxt = '{en: 1'b1, sel: s, data: d, mask: mtab[m], fault: 1'b0, link: 1'b0};
                end
            end
            cur[k] = nxt;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input int k, input logic v, input logic [3:0] s, input logic [31:0] d,
                         input logic [1:0] m);
        a_valid[k] = v; a_sel[k] = s; a_data[k] = d; a_mask[k] = m;
    endtask

    task automatic drv_b(input int k, input logic v, input logic [3:0] s, input logic [31:0] d,
                         input logic [1:0] m);
        b_valid[k] = v; b_sel[k] = s; b_data[k] = d; b_mask[k] = m;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        mtab = '{32'h0000_00FF, 32'h0000_FFFF, 32'h00FF_FFFF, 32'hFFFF_FFFF};
        for (int k = 0; k < N; k++) begin
            cur[k] = no_wr(); pend[k] = no_wr(); last_b[k] = 1'b1;
            acc_a[k] = 1'b0; acc_b[k] = 1'b0;
        end
        a_valid = '0; b_valid = '0; a_sel = '0; b_sel = '0; a_data = '0; b_data = '0;
        a_mask = '0; b_mask = '0; pc_in = '0; mode = '0;

        // Reset state
        step();
        @(negedge clk);
        chk("reset wr_en", wr_en[0], 0);
        chk("reset wr_data", wr_data[0], 0);
        chk("reset busy", busy[0], 0);
        step();
        rst = 1'b0;

        // Simple write
        drv_a(0, 1, 4'd3, 32'h1234_5678, 2'd1);
        @(negedge clk);
        chk("simple a_ready", a_ready[0], 1);
        step();
        drv_a(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("simple wr_en", wr_en[0], 1);
        chk("simple wr_sel", wr_sel[0], 3);
        chk("simple wr_data", wr_data[0], 32'h1234_5678);
        chk("simple wr_mask", wr_mask[0], 32'h0000_FFFF);
        step();

        // Round-robin on the FAIR=1 instance
        do_rst();
        drv_a(0, 1, 4'd1, 32'h11, 2'd3);
        drv_b(0, 1, 4'd2, 32'h22, 2'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                chk("rr a_ready", a_ready[0], (i % 2 == 0));
                chk("rr b_ready", b_ready[0], (i % 2 == 1));
            end
            if (i > 0) chk("rr wr_sel", wr_sel[0], (i % 2 == 1) ? 1 : 2);
            step();
            if (i == 3) begin drv_a(0, 0, 0, 0, 0); drv_b(0, 0, 0, 0, 0); end
        end

        // Fixed priority on the FAIR=0 instance
        do_rst();
        drv_a(1, 1, 4'd1, 32'h11, 2'd3);
        drv_b(1, 1, 4'd2, 32'h22, 2'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 3) begin
                chk("fp a_ready", a_ready[1], 1);
                chk("fp b_ready", b_ready[1], 0);
            end
            if (i > 0) chk("fp wr_sel", wr_sel[1], 1);
            step();
            if (i == 2) drv_a(1, 0, 0, 0, 0);
        end
        drv_b(1, 0, 0, 0, 0);
        @(negedge clk);
        step();

        // PCLINK with LINK_OFFSET=1, then a request accepted in cycle +2
        do_rst();
        pc_in[0] = 32'h100;
        drv_b(0, 1, 4'hE, 32'h2000, 2'd3);
        @(negedge clk);
        chk("pclink b_ready", b_ready[0], 1);
        step();
        drv_b(0, 0, 0, 0, 0);
        pc_in[0] = 32'h555;
        drv_a(0, 1, 4'd5, 32'hAA, 2'd0);
        @(negedge clk);
        chk("pclink +1 wr_sel", wr_sel[0], 4'hD);
        chk("pclink +1 wr_data", wr_data[0], 32'h101);
        chk("pclink +1 wr_mask", wr_mask[0], 32'hFFFF_FFFF);
        chk("pclink +1 busy", busy[0], 1);
        chk("pclink +1 a_ready", a_ready[0], 0);
        step();
        @(negedge clk);
        chk("pclink +2 wr_sel", wr_sel[0], 4'hF);
        chk("pclink +2 wr_data", wr_data[0], 32'h2000);
        chk("pclink +2 busy", busy[0], 0);
        chk("pclink +2 a_ready", a_ready[0], 1);
        step();
        drv_a(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pclink +3 wr_sel", wr_sel[0], 5);
        chk("pclink +3 wr_mask", wr_mask[0], 32'h0000_00FF);
        step();

        // PCLINK with LINK_OFFSET wrapping modulo 2^32
        pc_in[1] = 32'h20;
        drv_b(1, 1, 4'hE, 32'h77, 2'd0);
        @(negedge clk);
        step();
        drv_b(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("wrap lr data", wr_data[1], 32'h10);
        step();
        @(negedge clk);
        chk("wrap pc mask", wr_mask[1], 32'h0000_00FF);
        step();

        // Reset during LINK drops the PC write
        pc_in[0] = 32'h40;
        drv_b(0, 1, 4'hE, 32'h3000, 2'd3);
        @(negedge clk);
        step();
        drv_b(0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midlink lr sel", wr_sel[0], 4'hD);
        step();
        rst = 1'b0;
        drv_a(0, 1, 4'd4, 32'h44, 2'd3);
        @(negedge clk);
        chk("midlink wr_en", wr_en[0], 0);
        chk("midlink wr_sel", wr_sel[0], 0);
        chk("midlink wr_data", wr_data[0], 0);
        chk("midlink busy", busy[0], 0);
        chk("midlink a_ready", a_ready[0], 1);
        step();
        drv_a(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midlink next wr_sel", wr_sel[0], 4);
        step();

        // STATUS write in USER then SUPERVISOR mode
        mode[0] = 1'b1;
        drv_a(0, 1, 4'hB, 32'hFF, 2'd3);
        @(negedge clk);
        chk("priv user a_ready", a_ready[0], 1);
        step();
        drv_a(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("priv user wr_en", wr_en[0], !PRIV);
        chk("priv user fault", priv_fault[0], PRIV);
        step();
        mode[0] = 1'b0;
        drv_a(0, 1, 4'hB, 32'hFF, 2'd3);
        @(negedge clk);
        step();
        drv_a(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("priv sup wr_en", wr_en[0], 1);
        chk("priv sup wr_sel", wr_sel[0], 4'hB);
        chk("priv sup fault", priv_fault[0], 0);
        step();

        // Random traffic; payload held until the model says it was accepted
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!a_valid[k] || acc_a[k])
                    drv_a(k, ($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15)),
                          $urandom, 2'($urandom_range(0, 3)));
                if (!b_valid[k] || acc_b[k])
                    drv_b(k, ($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0) ? 4'hE : 4'($urandom_range(0, 15)),
                          $urandom, 2'($urandom_range(0, 3)));
                pc_in[k] = $urandom;
                mode[k]  = 1'($urandom_range(0, 1));
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        a_valid = '0;
        b_valid = '0;
        step();
        step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
